// File: rtl/prog_modn_counter.sv
// Runtime-programmable modulo-N counter with prescaler,
// up/down counting and wrap / one-shot / ping-pong modes.
module prog_modn_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [WIDTH-1:0] i_limit,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_done,
  output logic             o_phase_down
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             phase_q, phase_d;
  logic [PW-1:0]    p_q, p_d;

  logic             is_pp, is_os, step, lim_z;
  logic [WIDTH-1:0] inc, dec, lim_m1, ld_val;

  assign is_pp  = (i_mode == 2'b10);
  assign is_os  = (i_mode == 2'b01);
  assign lim_z  = (i_limit == '0);
  assign inc    = count_q + ONE;
  assign dec    = count_q - ONE;
  assign lim_m1 = lim_z ? '0 : (i_limit - ONE);
  assign ld_val = (i_load_value > i_limit)
                ? i_limit : i_load_value;
  assign step   = i_enable && !i_clear && !i_load
                && (p_q == P_LAST);

  // Next state: clear > load > prescaler/step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    phase_d = phase_q;
    p_d     = p_q;
    if (!is_pp) phase_d = 1'b0;
    if (!is_os) done_d  = 1'b0;
    if (i_clear) begin
      count_d = '0;
      done_d  = 1'b0;
      phase_d = 1'b0;
      p_d     = '0;
    end else if (i_load) begin
      count_d = ld_val;
      done_d  = 1'b0;
      phase_d = 1'b0;
      p_d     = '0;
    end else if (i_enable) begin
      p_d = step ? '0 : p_q + 1'b1;
    end
    if (step) begin
      unique case (1'b1)
        is_pp: begin
          if (!phase_q) begin
            if (count_q < i_limit) begin
              count_d = inc;
            end else begin
              count_d = lim_m1;
              phase_d = 1'b1;
              tc_d    = 1'b1;
            end
          end else begin
            if (count_q != '0) begin
              count_d = dec;
            end else begin
              count_d = lim_z ? '0 : ONE;
              phase_d = 1'b0;
              tc_d    = 1'b1;
            end
          end
        end
        is_os: begin
          if (!done_q) begin
            if (!i_dir) begin
              if (count_q >= i_limit) begin
                count_d = i_limit;
                done_d  = 1'b1;
                tc_d    = 1'b1;
              end else begin
                count_d = inc;
                if (inc == i_limit) begin
                  done_d = 1'b1;
                  tc_d   = 1'b1;
                end
              end
            end else begin
              if (count_q == '0) begin
                done_d = 1'b1;
                tc_d   = 1'b1;
              end else begin
                count_d = dec;
                if (dec == '0) begin
                  done_d = 1'b1;
                  tc_d   = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          if (!i_dir) begin
            if (count_q < i_limit) begin
              count_d = inc;
            end else begin
              count_d = '0;
              tc_d    = 1'b1;
            end
          end else begin
            if (count_q == '0 || count_q > i_limit) begin
              count_d = i_limit;
              tc_d    = 1'b1;
            end else begin
              count_d = dec;
            end
          end
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= WIDTH'(RESET_VALUE);
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
      p_q     <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      p_q     <= p_d;
    end
  end

  assign o_count      = count_q;
  assign o_tc         = tc_q;
  assign o_done       = done_q;
  assign o_phase_down = phase_q;

endmodule

// File: tb/tb_prog_modn_counter.sv
// Self-checking bench for prog_modn_counter.
// Expected {count,tc,done,phase} tuples are queued then popped.
module tb_prog_modn_counter;

  logic       clock;
  logic       reset;
  logic       enable, clear, load, dir;
  logic [7:0] load_value, limit;
  logic [1:0] mode;

  logic [7:0] cnt_a, cnt_b;
  logic       tc_a, done_a, ph_a;
  logic       tc_b, done_b, ph_b;
  logic [10:0] obs_a, obs_b;

  logic [10:0] sb[$];
  int nchk = 0;
  int nerr = 0;

  assign obs_a = {cnt_a, tc_a, done_a, ph_a};
  assign obs_b = {cnt_b, tc_b, done_b, ph_b};

  prog_modn_counter #(
    .WIDTH(8), .RESET_VALUE(5), .PRESCALE(1)
  ) u_a (
    .clock(clock), .reset(reset),
    .i_enable(enable), .i_clear(clear),
    .i_load(load), .i_load_value(load_value),
    .i_limit(limit), .i_mode(mode), .i_dir(dir),
    .o_count(cnt_a), .o_tc(tc_a),
    .o_done(done_a), .o_phase_down(ph_a)
  );

  prog_modn_counter #(
    .WIDTH(8), .RESET_VALUE(0), .PRESCALE(4)
  ) u_b (
    .clock(clock), .reset(reset),
    .i_enable(enable), .i_clear(clear),
    .i_load(load), .i_load_value(load_value),
    .i_limit(limit), .i_mode(mode), .i_dir(dir),
    .o_count(cnt_b), .o_tc(tc_b),
    .o_done(done_b), .o_phase_down(ph_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [10:0] mk(
    input int c, input bit t, input bit d, input bit p);
    return {8'(c), t, d, p};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1; load = 0; enable = 0;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    #1;
    nchk++;
    if (obs_a !== mk(5, 0, 0, 0)) begin
      nerr++;
      $display("FAIL reset_a got %h exp %h", obs_a, mk(5, 0, 0, 0));
    end
    nchk++;
    if (obs_b !== mk(0, 0, 0, 0)) begin
      nerr++;
      $display("FAIL reset_b got %h exp %h", obs_b, mk(0, 0, 0, 0));
    end
    #10 reset = 0;
    enable = 1; limit = 3; mode = 0; dir = 0;
    sb.push_back(mk(0, 1, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL reset_run got %h exp %h", obs_a, e);
      end
    end
    #3 reset = 1;
    #1;
    nchk++;
    if (obs_a !== mk(5, 0, 0, 0)) begin
      nerr++;
      $display("FAIL reset_mid got %h exp %h", obs_a, mk(5, 0, 0, 0));
    end
    #2 reset = 0;
    sb.push_back(mk(0, 1, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL reset_resume got %h exp %h", obs_a, e);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] e;
    do_clear();
    enable = 1; limit = 3; mode = 0; dir = 0;
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(3, 0, 0, 0));
    sb.push_back(mk(0, 1, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL wrap_up got %h exp %h", obs_a, e);
      end
    end
    do_clear();
    enable = 1; dir = 1;
    sb.push_back(mk(3, 1, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0));
    sb.push_back(mk(3, 1, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL wrap_down got %h exp %h", obs_a, e);
      end
    end
  endtask

  task automatic test_limit_drop();
    logic [10:0] e;
    enable = 1; dir = 0; mode = 0; limit = 255;
    load = 1; load_value = 200;
    sb.push_back(mk(200, 0, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL drop_load got %h exp %h", obs_a, e);
    end
    load = 0; limit = 10;
    sb.push_back(mk(0, 1, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL limit_drop got %h exp %h", obs_a, e);
      end
    end
  endtask

  task automatic test_prescale();
    logic [10:0] e;
    do_clear();
    enable = 1; limit = 255; mode = 0; dir = 0;
    sb.push_back(mk(0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_b !== e) begin
        nerr++;
        $display("FAIL presc_run got %h exp %h", obs_b, e);
      end
    end
    enable = 0;
    for (int i = 0; i < 3; i++) sb.push_back(mk(1, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_b !== e) begin
        nerr++;
        $display("FAIL presc_hold got %h exp %h", obs_b, e);
      end
    end
    enable = 1;
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(3, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_b !== e) begin
        nerr++;
        $display("FAIL presc_resume got %h exp %h", obs_b, e);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [10:0] e;
    mode = 2'b01; dir = 0; limit = 5;
    do_clear();
    enable = 1;
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(3, 0, 0, 0));
    sb.push_back(mk(4, 0, 0, 0));
    sb.push_back(mk(5, 1, 1, 0));
    sb.push_back(mk(5, 0, 1, 0));
    sb.push_back(mk(5, 0, 1, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL oneshot got %h exp %h", obs_a, e);
      end
    end
    load = 1; load_value = 2;
    sb.push_back(mk(2, 0, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL os_load got %h exp %h", obs_a, e);
    end
    load = 0;
    sb.push_back(mk(3, 0, 0, 0));
    sb.push_back(mk(4, 0, 0, 0));
    sb.push_back(mk(5, 1, 1, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL os_rerun got %h exp %h", obs_a, e);
      end
    end
  endtask

  task automatic test_pingpong();
    logic [10:0] e;
    mode = 2'b10; dir = 1; limit = 3;
    do_clear();
    enable = 1;
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(3, 0, 0, 0));
    sb.push_back(mk(2, 1, 0, 1));
    sb.push_back(mk(1, 0, 0, 1));
    sb.push_back(mk(0, 0, 0, 1));
    sb.push_back(mk(1, 1, 0, 0));
    sb.push_back(mk(2, 0, 0, 0));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL pingpong got %h exp %h", obs_a, e);
      end
    end
    limit = 0;
    do_clear();
    enable = 1;
    sb.push_back(mk(0, 1, 0, 1));
    sb.push_back(mk(0, 1, 0, 0));
    sb.push_back(mk(0, 1, 0, 1));
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      nchk++;
      if (obs_a !== e) begin
        nerr++;
        $display("FAIL pp_zero got %h exp %h", obs_a, e);
      end
    end
  endtask

  task automatic test_priority();
    logic [10:0] e;
    mode = 0; dir = 0; limit = 3; enable = 1;
    load = 1; load_value = 3;
    sb.push_back(mk(3, 0, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL prio_setup got %h exp %h", obs_a, e);
    end
    clear = 1; load = 1; load_value = 2;
    sb.push_back(mk(0, 0, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL prio_clear got %h exp %h", obs_a, e);
    end
    clear = 0; load = 1; load_value = 8'hFF; limit = 7;
    sb.push_back(mk(7, 0, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL prio_clamp got %h exp %h", obs_a, e);
    end
    load = 0;
    sb.push_back(mk(0, 1, 0, 0));
    tick();
    e = sb.pop_front();
    nchk++;
    if (obs_a !== e) begin
      nerr++;
      $display("FAIL prio_after got %h exp %h", obs_a, e);
    end
  endtask

  initial begin
    reset = 1; enable = 0; clear = 0; load = 0;
    load_value = 0; limit = 0; mode = 0; dir = 0;
    test_reset();
    test_wrap();
    test_limit_drop();
    test_prescale();
    test_oneshot();
    test_pingpong();
    test_priority();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
